// File: rtl/regfile_mp_if.sv
// Read/write-back bus between decode, execute/memory write-back and the register file.
interface regfile_mp_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned IDX_W  = 4
);
    logic [IDX_W-1:0]  src_a;
    logic [IDX_W-1:0]  src_b;
    logic [IDX_W-1:0]  dst_e;
    logic [IDX_W-1:0]  dst_m;
    logic [DATA_W-1:0] val_e;
    logic [DATA_W-1:0] val_m;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;
    logic              ready;
    logic              err;

    modport master (
        output src_a, src_b, dst_e, dst_m, val_e, val_m,
        input  val_a, val_b, ready, err
    );

    modport slave (
        input  src_a, src_b, dst_e, dst_m, val_e, val_m,
        output val_a, val_b, ready, err
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: two combinational read ports, two write-back ports
// (M beats E on a shared destination), optional write-to-read bypass and a
// sequential init fill after reset instead of an array reset.
module regfile_mp #(
    parameter int unsigned      DATA_W    = 64,
    parameter int unsigned      NREGS     = 15,
    parameter int unsigned      IDX_W     = 4,
    parameter logic [IDX_W-1:0] NONE_ID   = '1,
    parameter bit               BYPASS    = 1'b1,
    parameter bit               INIT_MODE = 1'b1
) (
    input logic          clk_i,
    input logic          rst_n_i,
    regfile_mp_if.slave  bus
);
    localparam int unsigned      CNT_W     = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NREGS - 1);
    localparam logic [IDX_W-1:0] NREGS_IDX = IDX_W'(NREGS);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] regs [NREGS];

    logic              run;
    logic              we_e, we_m;
    logic              oor_e, oor_m;
    logic [DATA_W-1:0] init_val;

    assign run      = (state_q == ST_RUN);
    assign we_e     = run && (bus.dst_e != NONE_ID) && (bus.dst_e <  NREGS_IDX);
    assign we_m     = run && (bus.dst_m != NONE_ID) && (bus.dst_m <  NREGS_IDX);
    assign oor_e    = run && (bus.dst_e != NONE_ID) && (bus.dst_e >= NREGS_IDX);
    assign oor_m    = run && (bus.dst_m != NONE_ID) && (bus.dst_m >= NREGS_IDX);
    assign init_val = INIT_MODE ? DATA_W'(cnt_q) : '0;

    // State, fill counter and status flags.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Next state: one init entry per cycle, then RUN until reset; err is sticky.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        err_d   = err_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                err_d = err_q | oor_e | oor_m;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Array update: init fill, else E then M so M wins a shared destination.
    always_ff @(posedge clk_i) begin
        if (!run) begin
            regs[cnt_q] <= init_val;
        end else begin
            if (we_e) regs[CNT_W'(bus.dst_e)] <= bus.val_e;
            if (we_m) regs[CNT_W'(bus.dst_m)] <= bus.val_m;
        end
    end

    // Read mux: invalid index -> 0, then M bypass, then E bypass, then array.
    function automatic logic [DATA_W-1:0] read_port(input logic [IDX_W-1:0] src);
        logic [DATA_W-1:0] v;
        if (!run || (src == NONE_ID) || (src >= NREGS_IDX)) begin
            v = '0;
        end else if (BYPASS && we_m && (bus.dst_m == src)) begin
            v = bus.val_m;
        end else if (BYPASS && we_e && (bus.dst_e == src)) begin
            v = bus.val_e;
        end else begin
            v = regs[CNT_W'(src)];
        end
        return v;
    endfunction

    assign bus.val_a = read_port(bus.src_a);
    assign bus.val_b = read_port(bus.src_b);
    assign bus.ready = ready_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Random and directed checks of three regfile_mp variants against a behavioural model:
// u0 defaults, u1 without bypass, u2 with 8 registers and zero init.
module tb_regfile_mp;
    localparam int NDUT = 3;
    localparam logic [3:0] NONE = 4'hf;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  src_a = 4'h0, src_b = 4'h0, dst_e = NONE, dst_m = NONE;
    logic [63:0] val_e = '0, val_m = '0;

    regfile_mp_if #(.DATA_W(64), .IDX_W(4)) if0 ();
    regfile_mp_if #(.DATA_W(64), .IDX_W(4)) if1 ();
    regfile_mp_if #(.DATA_W(64), .IDX_W(4)) if2 ();

    assign if0.src_a = src_a; assign if0.src_b = src_b; assign if0.dst_e = dst_e;
    assign if0.dst_m = dst_m; assign if0.val_e = val_e; assign if0.val_m = val_m;
    assign if1.src_a = src_a; assign if1.src_b = src_b; assign if1.dst_e = dst_e;
    assign if1.dst_m = dst_m; assign if1.val_e = val_e; assign if1.val_m = val_m;
    assign if2.src_a = src_a; assign if2.src_b = src_b; assign if2.dst_e = dst_e;
    assign if2.dst_m = dst_m; assign if2.val_e = val_e; assign if2.val_m = val_m;

    regfile_mp u0 (.clk_i(clk), .rst_n_i(rst_n), .bus(if0.slave));
    regfile_mp #(.NREGS(15), .BYPASS(1'b0)) u1 (.clk_i(clk), .rst_n_i(rst_n), .bus(if1.slave));
    regfile_mp #(.NREGS(8), .INIT_MODE(1'b0)) u2 (.clk_i(clk), .rst_n_i(rst_n), .bus(if2.slave));

    logic [63:0] got_a [NDUT];
    logic [63:0] got_b [NDUT];
    logic        got_rdy [NDUT];
    logic        got_err [NDUT];
    assign got_a[0] = if0.val_a; assign got_b[0] = if0.val_b;
    assign got_rdy[0] = if0.ready; assign got_err[0] = if0.err;
    assign got_a[1] = if1.val_a; assign got_b[1] = if1.val_b;
    assign got_rdy[1] = if1.ready; assign got_err[1] = if1.err;
    assign got_a[2] = if2.val_a; assign got_b[2] = if2.val_b;
    assign got_rdy[2] = if2.ready; assign got_err[2] = if2.err;

    // Reference model: architectural contents plus edges seen since reset release.
    int          nregs_p [NDUT] = '{15, 15, 8};
    bit          byp_p   [NDUT] = '{1'b1, 1'b0, 1'b1};
    bit          init_p  [NDUT] = '{1'b1, 1'b1, 1'b0};
    logic [63:0] m_reg   [NDUT][16];
    int          m_cyc   [NDUT];
    bit          m_err   [NDUT];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_ready(input int k);
        return m_cyc[k] >= nregs_p[k];
    endfunction

    function automatic logic [63:0] m_read(input int k, input logic [3:0] s);
        if (!m_ready(k)) return 64'h0;
        if (s == NONE || int'(s) >= nregs_p[k]) return 64'h0;
        if (byp_p[k] && dst_m == s) return val_m;
        if (byp_p[k] && dst_e == s) return val_e;
        return m_reg[k][s];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_cyc[k] = 0;
            m_err[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < NDUT; k++) begin
            if (!m_ready(k)) begin
                m_reg[k][m_cyc[k]] = init_p[k] ? 64'(m_cyc[k]) : 64'h0;
                m_cyc[k]++;
            end else begin
                if (dst_e != NONE) begin
                    if (int'(dst_e) < nregs_p[k]) m_reg[k][dst_e] = val_e;
                    else m_err[k] = 1'b1;
                end
                if (dst_m != NONE) begin
                    if (int'(dst_m) < nregs_p[k]) m_reg[k][dst_m] = val_m;
                    else m_err[k] = 1'b1;
                end
            end
        end
    endtask

    // Let inputs settle, then compare every output of every variant with the model.
    task automatic settle_check();
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("u%0d.val_a", k), got_a[k], m_read(k, src_a));
            check($sformatf("u%0d.val_b", k), got_b[k], m_read(k, src_b));
            check($sformatf("u%0d.ready", k), 64'(got_rdy[k]), 64'(m_ready(k)));
            check($sformatf("u%0d.err", k), 64'(got_err[k]), 64'(m_err[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        dst_e = NONE; dst_m = NONE; val_e = '0; val_m = '0;
    endtask

    int low_cnt;

    initial begin
        model_reset();
        @(negedge clk);
        settle_check();
        @(negedge clk);
        rst_n = 1'b1;

        // Init fill with src A=3, B=14; count cycles before ready.
        src_a = 4'd3; src_b = 4'd14;
        low_cnt = 0;
        for (int i = 0; i < 18; i++) begin
            settle_check();
            if (!got_rdy[0]) low_cnt++;
            tick();
        end
        check("init_len", 64'(low_cnt), 64'd15);
        #1;
        check("init_a3", got_a[0], 64'h3);
        check("init_b14", got_b[0], 64'he);

        // Dual write to the same destination: M wins.
        dst_e = 4'd4; val_e = 64'h100; dst_m = 4'd4; val_m = 64'h200; src_a = 4'd4;
        settle_check();
        check("dual_byp_same_cycle", got_a[0], 64'h200);
        check("dual_nobyp_same_cycle", got_a[1], 64'h4);
        tick();
        idle();
        settle_check();
        check("dual_after", got_a[1], 64'h200);

        // Bypass versus stored-only reads.
        dst_e = 4'd2; val_e = 64'hDEAD; src_b = 4'd2;
        settle_check();
        check("byp_b", got_b[0], 64'hDEAD);
        check("nobyp_b_old", got_b[1], 64'h2);
        tick();
        idle();
        settle_check();
        check("nobyp_b_new", got_b[1], 64'hDEAD);

        // NONE_ID write is dropped and reads of NONE_ID return 0.
        dst_e = NONE; val_e = 64'h55; src_a = NONE;
        settle_check();
        tick();
        idle();
        settle_check();
        check("none_read", got_a[0], 64'h0);
        check("none_err", 64'(got_err[0]), 64'h0);

        // Out-of-range M write on the 8-entry variant.
        dst_m = 4'd9; val_m = 64'h99; src_a = 4'd9;
        settle_check();
        tick();
        idle();
        settle_check();
        check("oor_err", 64'(got_err[2]), 64'h1);
        check("oor_read", got_a[2], 64'h0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            src_a = 4'($urandom_range(0, 15));
            src_b = ($urandom_range(0, 3) == 0) ? src_a : 4'($urandom_range(0, 15));
            dst_e = 4'($urandom_range(0, 15));
            dst_m = ($urandom_range(0, 4) == 0) ? dst_e : 4'($urandom_range(0, 15));
            val_e = {$urandom, $urandom};
            val_m = {$urandom, $urandom};
            settle_check();
            tick();
        end

        // Write reg5, then reset between edges.
        idle();
        dst_e = 4'd5; val_e = 64'h77;
        settle_check();
        tick();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_ready_drop", 64'(got_rdy[0]), 64'h0);
        check("rst_err_drop", 64'(got_err[2]), 64'h0);
        model_reset();
        settle_check();
        @(negedge clk);
        rst_n = 1'b1;

        // Re-init with a write attempt in init cycle 2.
        src_a = 4'd5; src_b = 4'd10;
        low_cnt = 0;
        for (int i = 0; i < 17; i++) begin
            idle();
            if (i == 2) begin dst_e = 4'd10; val_e = 64'hAB; end
            settle_check();
            if (!got_rdy[0]) low_cnt++;
            tick();
        end
        idle();
        check("reinit_len", 64'(low_cnt), 64'd15);
        settle_check();
        check("reinit_reg5", got_a[0], 64'h5);
        check("reinit_reg10", got_b[0], 64'ha);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
